// File: rtl/ece453_gpio_debounce_irq.sv
// rtl/ece453_gpio_debounce_irq.sv - multi-channel GPIO debouncer with edge interrupts and Avalon-MM registers
//
// Purpose: conditions NUM_CH raw asynchronous inputs (buttons, switches). Each
// channel is synchronised, optionally inverted, sampled on a shared prescaler
// tick and debounced. Edges on the debounced level raise maskable W1C interrupts.
//
// Ports:
//   clk              sole clock
//   reset            synchronous, active-high
//   gpio_in          raw asynchronous inputs, one bit per channel
//   slave_address    word address of the register window
//   slave_read       read strobe; slave_readdata is zero when low
//   slave_write      write strobe
//   slave_writedata  write data
//   slave_readdata   combinational read data
//   db_state         debounced levels
//   rise_pulse       one-cycle pulse on a debounced 0->1 transition
//   fall_pulse       one-cycle pulse on a debounced 1->0 transition
//   irq_out          OR of pending interrupts that are unmasked
//
// Register map (word address):
//   0 ID (RO)  1 STATE (RO)  2 RAW (RO)  3 RISE_EN  4 FALL_EN  5 IM  6 IRQ (W1C)  7 reads 0

module ece453_gpio_debounce_irq #(
    parameter int                NUM_CH        = 8,
    parameter int                SAMPLE_PERIOD = 500000,
    parameter int                NUM_SAMPLES   = 8,
    parameter logic [NUM_CH-1:0] INVERT_MASK   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] gpio_in,
    input  logic [2:0]        slave_address,
    input  logic              slave_read,
    input  logic              slave_write,
    input  logic [31:0]       slave_writedata,
    output logic [31:0]       slave_readdata,
    output logic [NUM_CH-1:0] db_state,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic              irq_out
);

    localparam logic [31:0]      ID_VALUE = 32'hECE45320;
    localparam int               CNT_W    = 24;
    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(SAMPLE_PERIOD - 1);

    localparam logic [2:0] ADDR_ID      = 3'd0;
    localparam logic [2:0] ADDR_STATE   = 3'd1;
    localparam logic [2:0] ADDR_RAW     = 3'd2;
    localparam logic [2:0] ADDR_RISE_EN = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN = 3'd4;
    localparam logic [2:0] ADDR_IM      = 3'd5;
    localparam logic [2:0] ADDR_IRQ     = 3'd6;

    // Registered state
    logic [NUM_CH-1:0]                  sync1_q, sync2_q;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [NUM_CH-1:0][NUM_SAMPLES-1:0] sh_q, sh_d;
    logic [NUM_CH-1:0]                  db_q, db_d;
    logic [NUM_CH-1:0]                  rise_q, rise_d;
    logic [NUM_CH-1:0]                  fall_q, fall_d;
    logic [NUM_CH-1:0]                  rise_en_q, rise_en_d;
    logic [NUM_CH-1:0]                  fall_en_q, fall_en_d;
    logic [NUM_CH-1:0]                  im_q, im_d;
    logic [NUM_CH-1:0]                  irq_q, irq_d;

    // Combinational helpers
    logic                               tick;
    logic [NUM_CH-1:0]                  raw_s;
    logic [NUM_CH-1:0]                  wdata_ch;
    logic [NUM_CH-1:0]                  clear;
    logic [31:0]                        rd_word;

    // Bits of the write bus above NUM_CH have no register behind them.
    logic unused_wdata;
    assign unused_wdata = ^slave_writedata;

    always_comb begin
        wdata_ch = slave_writedata[NUM_CH-1:0];
        raw_s    = sync2_q ^ INVERT_MASK;

        // Shared down-counter; reload in the tick cycle so there is no gap.
        tick  = (cnt_q == '0);
        cnt_d = tick ? RELOAD : cnt_q - CNT_W'(1);

        for (int i = 0; i < NUM_CH; i++) begin
            sh_d[i] = tick ? {sh_q[i][NUM_SAMPLES-2:0], raw_s[i]} : sh_q[i];
            // Level changes only once the whole sample window agrees.
            if (&sh_q[i]) begin
                db_d[i] = 1'b1;
            end else if (sh_q[i] == '0) begin
                db_d[i] = 1'b0;
            end else begin
                db_d[i] = db_q[i];
            end
        end

        rise_d = db_d & ~db_q;
        fall_d = ~db_d & db_q;

        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        im_d      = im_q;
        clear     = '0;
        if (slave_write) begin
            case (slave_address)
                ADDR_RISE_EN: rise_en_d = wdata_ch;
                ADDR_FALL_EN: fall_en_d = wdata_ch;
                ADDR_IM:      im_d      = wdata_ch;
                ADDR_IRQ:     clear     = wdata_ch;
                default:      ;
            endcase
        end

        // New events are ORed after the clear so a set wins a same-cycle clear.
        // The enables in effect are the ones before any same-cycle write.
        irq_d = (irq_q & ~clear) | (rise_d & rise_en_q) | (fall_d & fall_en_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            cnt_q     <= RELOAD;
            sh_q      <= '0;
            db_q      <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            im_q      <= '0;
            irq_q     <= '0;
        end else begin
            sync1_q   <= gpio_in;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            db_q      <= db_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            im_q      <= im_d;
            irq_q     <= irq_d;
        end
    end

    // Zero-wait read path; register bits at NUM_CH and above stay 0.
    always_comb begin
        rd_word = '0;
        case (slave_address)
            ADDR_ID:      rd_word                = ID_VALUE;
            ADDR_STATE:   rd_word[NUM_CH-1:0]    = db_q;
            ADDR_RAW:     rd_word[NUM_CH-1:0]    = raw_s;
            ADDR_RISE_EN: rd_word[NUM_CH-1:0]    = rise_en_q;
            ADDR_FALL_EN: rd_word[NUM_CH-1:0]    = fall_en_q;
            ADDR_IM:      rd_word[NUM_CH-1:0]    = im_q;
            ADDR_IRQ:     rd_word[NUM_CH-1:0]    = irq_q;
            default:      ;
        endcase
        slave_readdata = slave_read ? rd_word : 32'h0;
    end

    assign db_state   = db_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign irq_out    = |(irq_q & im_q);

endmodule
